// File: rtl/switch_conditioner_pkg.sv
// Shared types and constants for the alarm switch front-end.
// Debounce state encoding and the channel index map used by every switch_conditioner file.
package alarm_pkg;

  typedef enum logic [1:0] {
    S_LO = 2'd0,
    W_HI = 2'd1,
    S_HI = 2'd2,
    W_LO = 2'd3
  } deb_state_e;

  localparam int unsigned CH_DRV = 0;
  localparam int unsigned CH_PAS = 1;
  localparam int unsigned CH_IGN = 2;
  localparam int unsigned CH_HID = 3;
  localparam int unsigned CH_BRK = 4;
  localparam int unsigned N_SW   = 5;

endpackage

// File: rtl/switch_conditioner_if.sv
// Raw vehicle switch inputs and conditioned outputs of the alarm front-end.
// The slave modport is the conditioner; the master modport is the switch source and FSM side.
interface switch_conditioner_if;

  logic driver_door_raw;
  logic passenger_door_raw;
  logic ignition_raw;
  logic hidden_raw;
  logic brake_raw;
  logic driver_door_switch;
  logic passenger_door_switch;
  logic ignition_switch;
  logic hidden_switch;
  logic brake_pedal_switch;
  logic sec_tick;
  logic tamper_flag;

  modport master (
    output driver_door_raw, passenger_door_raw, ignition_raw, hidden_raw, brake_raw,
    input  driver_door_switch, passenger_door_switch, ignition_switch, hidden_switch,
    input  brake_pedal_switch, sec_tick, tamper_flag
  );

  modport slave (
    input  driver_door_raw, passenger_door_raw, ignition_raw, hidden_raw, brake_raw,
    output driver_door_switch, passenger_door_switch, ignition_switch, hidden_switch,
    output brake_pedal_switch, sec_tick, tamper_flag
  );

endinterface

// File: rtl/switch_conditioner_debounce.sv
// One switch channel: 2-flop synchroniser followed by a counting debounce FSM.
// abort_o pulses on the edge where a pending transition is abandoned.
module switch_debounce
  import alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic sw_o,
  output logic abort_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q, sync2_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= S_LO;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The debounced level is implied by the state: high while stable-high or waiting to fall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_o = 1'b0;
    unique case (state_q)
      S_LO: if (sync2_q) begin
        state_d = W_HI;
        cnt_d   = CNT_ONE;
      end
      S_HI: if (!sync2_q) begin
        state_d = W_LO;
        cnt_d   = CNT_ONE;
      end
      W_HI: begin
        if (sync2_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_HI;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = S_LO;
          cnt_d   = '0;
          abort_o = 1'b1;
        end
      end
      W_LO: begin
        if (!sync2_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = S_HI;
          cnt_d   = '0;
          abort_o = 1'b1;
        end
      end
      default: begin
        state_d = S_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign sw_o = (state_q == S_HI) || (state_q == W_LO);

endmodule

// File: rtl/switch_conditioner.sv
// Alarm input front-end: five debounced switches, 1 s tick and door-tamper detection.
// Define TAMPER_DETECT_EN to build the tamper counter; otherwise tamper_flag is tied low.
module switch_conditioner
  import alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned TAMPER_THRESH   = 8
) (
  input logic           clk,
  input logic           rst,
  switch_conditioner_if.slave sw_if
);

  localparam int unsigned TKW = $clog2(TICK_DIV);
  localparam logic [TKW-1:0] TICK_LAST = TKW'(TICK_DIV - 1);

  logic [N_SW-1:0] raw, sw, abort;
  logic [TKW-1:0]  tick_cnt_q, tick_cnt_d;
  logic            sec_tick_q, sec_tick_d;

  assign raw[CH_DRV] = sw_if.driver_door_raw;
  assign raw[CH_PAS] = sw_if.passenger_door_raw;
  assign raw[CH_IGN] = sw_if.ignition_raw;
  assign raw[CH_HID] = sw_if.hidden_raw;
  assign raw[CH_BRK] = sw_if.brake_raw;

  for (genvar g = 0; g < N_SW; g++) begin : g_ch
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw[g]),
      .sw_o    (sw[g]),
      .abort_o (abort[g])
    );
  end

  assign sw_if.driver_door_switch    = sw[CH_DRV];
  assign sw_if.passenger_door_switch = sw[CH_PAS];
  assign sw_if.ignition_switch       = sw[CH_IGN];
  assign sw_if.hidden_switch         = sw[CH_HID];
  assign sw_if.brake_pedal_switch    = sw[CH_BRK];

  always_comb begin
    sec_tick_d = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = sec_tick_d ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign sw_if.sec_tick = sec_tick_q;

`ifdef TAMPER_DETECT_EN
  localparam int unsigned TCW = $clog2(TAMPER_THRESH + 1);
  localparam logic [TCW:0] TH_W = (TCW + 1)'(TAMPER_THRESH);

  logic [1:0]     door_aborts;
  logic [TCW:0]   base, sum;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           flag_q, flag_d;
  logic           unused_abort;

  assign unused_abort = ^{abort[CH_IGN], abort[CH_HID], abort[CH_BRK]};
  assign door_aborts  = {1'b0, abort[CH_DRV]} + {1'b0, abort[CH_PAS]};

  // A tick restarts the window, so aborts landing on the tick cycle seed the new count.
  always_comb begin
    base   = sec_tick_q ? '0 : {1'b0, tcnt_q};
    sum    = base + (TCW + 1)'(door_aborts);
    tcnt_d = (sum >= TH_W) ? TH_W[TCW-1:0] : sum[TCW-1:0];
    flag_d = flag_q | (sum >= TH_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
      flag_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      flag_q <= flag_d;
    end
  end

  assign sw_if.tamper_flag = flag_q;
`else
  localparam int unsigned unused_thresh = TAMPER_THRESH;
  logic unused_abort;

  assign unused_abort      = ^abort;
  assign sw_if.tamper_flag = 1'b0;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed scenarios plus randomized chatter,
// checked every cycle against a run-length model of the switch rules.
module tb_switch_conditioner;
  import alarm_pkg::*;

  localparam int unsigned DEB = 4;
  localparam int unsigned TDIV = 10;
  localparam int unsigned TTH = 4;
`ifdef TAMPER_DETECT_EN
  localparam bit TAMPER_ON = 1'b1;
`else
  localparam bit TAMPER_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_SW-1:0] raw = '0;
  logic [N_SW-1:0] dut_sw;

  int n_tests = 0;
  int n_fail  = 0;
  string nm [N_SW] = '{"drv", "pas", "ign", "hid", "brk"};

  switch_conditioner_if sw_if ();

  switch_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .TICK_DIV        (TDIV),
    .TAMPER_THRESH   (TTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sw_if (sw_if)
  );

  always #5 clk = ~clk;

  assign sw_if.driver_door_raw    = raw[CH_DRV];
  assign sw_if.passenger_door_raw = raw[CH_PAS];
  assign sw_if.ignition_raw       = raw[CH_IGN];
  assign sw_if.hidden_raw         = raw[CH_HID];
  assign sw_if.brake_raw          = raw[CH_BRK];

  assign dut_sw[CH_DRV] = sw_if.driver_door_switch;
  assign dut_sw[CH_PAS] = sw_if.passenger_door_switch;
  assign dut_sw[CH_IGN] = sw_if.ignition_switch;
  assign dut_sw[CH_HID] = sw_if.hidden_switch;
  assign dut_sw[CH_BRK] = sw_if.brake_pedal_switch;

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each output flips once DEB consecutive synchronised samples disagree with it.
  bit [N_SW-1:0] m_h1, m_h2, m_out;
  int            m_run [N_SW];
  int unsigned   m_edges;
  int            m_tcnt;
  bit            m_flag, m_tick;

  always begin
    int ab;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_h1 = '0; m_h2 = '0; m_out = '0;
      for (int c = 0; c < N_SW; c++) m_run[c] = 0;
      m_edges = 0; m_tcnt = 0; m_flag = 1'b0; m_tick = 1'b0;
    end else begin
      ab = 0;
      for (int c = 0; c < N_SW; c++) begin
        if (m_h2[c] != m_out[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_out[c] = ~m_out[c];
            m_run[c] = 0;
          end
        end else begin
          if (m_run[c] > 0 && (c == CH_DRV || c == CH_PAS)) ab++;
          m_run[c] = 0;
        end
      end
      m_h2 = m_h1;
      m_h1 = raw;
      m_tcnt = m_tick ? ab : m_tcnt + ab;
      if (m_tcnt >= TTH) begin
        m_tcnt = TTH;
        if (TAMPER_ON) m_flag = 1'b1;
      end
      m_edges++;
      m_tick = (m_edges % TDIV == 0);
    end
  end

  always begin
    @(negedge clk);
    for (int c = 0; c < N_SW; c++) check({"model_", nm[c]}, dut_sw[c], m_out[c]);
    check("model_tick", sw_if.sec_tick, m_tick);
    check("model_tamper", sw_if.tamper_flag, m_flag);
  end

  task automatic do_reset(input logic [N_SW-1:0] r);
    @(negedge clk);
    #2 rst = 1'b1;
    raw = r;
    @(negedge clk);
    for (int c = 0; c < N_SW; c++) check({"rst_", nm[c]}, dut_sw[c], 1'b0);
    check("rst_tick", sw_if.sec_tick, 1'b0);
    check("rst_tamper", sw_if.tamper_flag, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [N_SW-1:0] mask;
    int mode;

    // All raws high through reset: outputs rise together on edge 6.
    do_reset('1);
    edges(5);
    check("t1_drv_e5", dut_sw[CH_DRV], 1'b0);
    edges(1);
    for (int c = 0; c < N_SW; c++) check({"t1_e6_", nm[c]}, dut_sw[c], 1'b1);

    // Driver door alone.
    do_reset(N_SW'(1) << CH_DRV);
    edges(5);
    check("t2_drv_e5", dut_sw[CH_DRV], 1'b0);
    edges(1);
    check("t2_drv_e6", dut_sw[CH_DRV], 1'b1);
    check("t2_others_e6", |(dut_sw & ~(N_SW'(1) << CH_DRV)), 1'b0);

    // Three-cycle ignition glitch is filtered out.
    do_reset(N_SW'(1) << CH_IGN);
    edges(3);
    raw[CH_IGN] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      edges(1);
      check("t3_ign_glitch", dut_sw[CH_IGN], 1'b0);
    end

    // Tick on edges 10, 20, 30 only.
    do_reset('0);
    for (int e = 1; e <= 31; e++) begin
      edges(1);
      check("t4_tick", sw_if.sec_tick, (e % 10 == 0));
    end

    // Passenger door chatter: aborts on edges 4, 6, 8, 10 reach the threshold on edge 10.
    do_reset(N_SW'(1) << CH_PAS);
    for (int e = 1; e <= 9; e++) begin
      edges(1);
      raw[CH_PAS] = logic'((e + 1) % 2);
    end
    check("t5_tamper_e9", sw_if.tamper_flag, 1'b0);
    edges(1);
    check("t5_tamper_e10", sw_if.tamper_flag, TAMPER_ON);
    edges(15);
    check("t5_tamper_held", sw_if.tamper_flag, TAMPER_ON);
    check("t5_pas_quiet", dut_sw[CH_PAS], 1'b0);

    // Reset in the middle of a brake debounce restarts it from scratch.
    do_reset(N_SW'(1) << CH_BRK);
    edges(3);
    #2 rst = 1'b1;
    @(negedge clk);
    check("t6_brk_in_rst", dut_sw[CH_BRK], 1'b0);
    rst = 1'b0;
    edges(5);
    check("t6_brk_e5", dut_sw[CH_BRK], 1'b0);
    edges(1);
    check("t6_brk_e6", dut_sw[CH_BRK], 1'b1);

    // Randomized chatter with varying flip density and occasional async resets.
    do_reset(N_SW'($urandom));
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      if (i % 150 == 0) mode = int'($urandom_range(0, 2));
      mask = '0;
      for (int c = 0; c < N_SW; c++) begin
        case (mode)
          0:       mask[c] = ($urandom_range(0, 1) == 0);
          1:       mask[c] = ($urandom_range(0, 7) == 0);
          default: mask[c] = ($urandom_range(0, 24) == 0);
        endcase
      end
      #2;
      raw = raw ^ mask;
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    edges(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
